vga_hexout: RTL and testbench



---
 rtl/vga_hexout_pkg.sv | 64 ++++++
 rtl/hexout_glyph.sv | 21 ++
 rtl/vga_hexout.sv | 211 +++++++++++++++++++++
 tb/tb_vga_hexout.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_hexout_pkg.sv
// Shared constants for the hex-digit VGA overlay: segment map, glyph geometry
// and the pixel classification used to pick a colour.
package vga_hexout_pkg;

  // Horizontal cell layout: three glyph columns followed by a blank gap.
  localparam int unsigned CELL_PITCH = 40;
  localparam int unsigned COL0_W     = 8;
  localparam int unsigned COL1_W     = 16;
  localparam int unsigned COL2_W     = 8;
  localparam int unsigned CELL_W     = COL0_W + COL1_W + COL2_W;

  // Vertical cell layout: five glyph bands.
  localparam int unsigned ROW0_H = 8;
  localparam int unsigned ROW1_H = 24;
  localparam int unsigned ROW2_H = 8;
  localparam int unsigned ROW3_H = 24;
  localparam int unsigned ROW4_H = 8;
  localparam int unsigned CELL_H = ROW0_H + ROW1_H + ROW2_H + ROW3_H + ROW4_H;

  // Segments lit per hex value, bit order gfedcba.
  localparam logic [6:0] SEG_MAP [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Segments that can light each glyph band/column; corners are shared by
  // the segments meeting there.
  localparam logic [6:0] GLYPH_MASK [5][3] = '{
    '{7'h21, 7'h01, 7'h03},
    '{7'h20, 7'h00, 7'h02},
    '{7'h70, 7'h40, 7'h46},
    '{7'h10, 7'h00, 7'h04},
    '{7'h18, 7'h08, 7'h0C}
  };

  typedef enum logic [1:0] {
    PIX_BLANK,
    PIX_BG,
    PIX_SEG,
    PIX_MARK
  } pix_kind_t;

  function automatic logic [1:0] glyph_col(input logic [31:0] px);
    if (px < COL0_W)                return 2'd0;
    else if (px < COL0_W + COL1_W)  return 2'd1;
    else if (px < CELL_W)           return 2'd2;
    else                            return 2'd3;
  endfunction

  function automatic logic [2:0] glyph_row(input logic [31:0] py);
    if (py < ROW0_H)                                   return 3'd0;
    else if (py < ROW0_H + ROW1_H)                     return 3'd1;
    else if (py < ROW0_H + ROW1_H + ROW2_H)            return 3'd2;
    else if (py < ROW0_H + ROW1_H + ROW2_H + ROW3_H)   return 3'd3;
    else if (py < CELL_H)                              return 3'd4;
    else                                               return 3'd7;
  endfunction

  function automatic logic [6:0] glyph_mask(input logic [1:0] col, input logic [2:0] grow);
    if (col > 2'd2 || grow > 3'd4) return '0;
    return GLYPH_MASK[grow][col];
  endfunction

endpackage

// File: rtl/hexout_glyph.sv
// Combinational 7-segment glyph lookup: is this glyph band/column lit for
// the given hex nibble.
module hexout_glyph
  import vga_hexout_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic [1:0] i_col,
  input  logic [2:0] i_grow,
  output logic       o_lit
);

  logic [6:0] w_segs;
  logic [6:0] w_mask;

  always_comb begin
    w_segs = SEG_MAP[i_nibble];
    w_mask = glyph_mask(i_col, i_grow);
    o_lit  = |(w_segs & w_mask);
  end

endmodule

// File: rtl/vga_hexout.sv
// VGA timing generator with a hex-digit overlay; displayed values, markers
// and enable are captured once per frame so the picture never tears.
module vga_hexout
  import vga_hexout_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 720,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 62,
  parameter int unsigned H_BP      = 61,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 30,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 9,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b1,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned X0        = 122,
  parameter int unsigned Y0        = 113,
  parameter int unsigned ROW_PITCH = 128,
  parameter int unsigned CW        = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [ROWS*4*DIGITS-1:0]   values,
  input  logic [ROWS*5-1:0]          marks,
  output logic                       hs,
  output logic                       vs,
  output logic                       de,
  output logic [CW-1:0]              r,
  output logic [CW-1:0]              g,
  output logic [CW-1:0]              b,
  output logic                       frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SEND   = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ASTART = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_AEND   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SEND   = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ASTART = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_AEND   = VW'(V_SYNC + V_BP + V_ACTIVE);

  logic [HW-1:0]              r_hcount;
  logic [VW-1:0]              r_vcount;
  logic [ROWS*4*DIGITS-1:0]   r_values;
  logic [ROWS*5-1:0]          r_marks;
  logic                       r_en;
  logic                       r_hs;
  logic                       r_vs;
  logic                       r_de;
  logic                       r_fs;
  logic [CW-1:0]              r_r;
  logic [CW-1:0]              r_g;
  logic [CW-1:0]              r_b;

  logic                       w_frame0;
  logic                       w_hact;
  logic                       w_vact;
  logic                       w_active;
  logic [31:0]                w_ax;
  logic [31:0]                w_ay;
  logic                       w_hit;
  logic                       w_odd;
  logic                       w_mark;
  logic [3:0]                 w_nib;
  logic [31:0]                w_px;
  logic [31:0]                w_py;
  logic [1:0]                 w_col;
  logic [2:0]                 w_grow;
  logic                       w_lit;
  pix_kind_t                  w_kind;
  logic [CW-1:0]              w_rc;
  logic [CW-1:0]              w_gc;
  logic [CW-1:0]              w_bc;

  // Raster counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (r_hcount == H_LAST) begin
      r_hcount <= '0;
      if (r_vcount == V_LAST) r_vcount <= '0;
      else                    r_vcount <= r_vcount + VW'(1);
    end else begin
      r_hcount <= r_hcount + HW'(1);
    end
  end

  assign w_frame0 = (r_hcount == '0) && (r_vcount == '0);

  // Per-frame snapshot of everything that affects the picture content.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_values <= '0;
      r_marks  <= '1;
      r_en     <= 1'b0;
    end else if (w_frame0) begin
      r_values <= values;
      r_marks  <= marks;
      r_en     <= enable;
    end
  end

  // Locate the digit cell under the current pixel. Cells never overlap, so at
  // most one loop iteration can hit; anything outside the active area is
  // masked later, which also clips cells that run past the right/bottom edge.
  always_comb begin
    w_hact   = (r_hcount >= H_ASTART) && (r_hcount < H_AEND);
    w_vact   = (r_vcount >= V_ASTART) && (r_vcount < V_AEND);
    w_active = w_hact && w_vact;
    w_ax     = 32'(r_hcount - H_ASTART);
    w_ay     = 32'(r_vcount - V_ASTART);
    w_hit    = 1'b0;
    w_odd    = 1'b0;
    w_mark   = 1'b0;
    w_nib    = '0;
    w_px     = '0;
    w_py     = '0;
    for (int unsigned rr = 0; rr < ROWS; rr++) begin
      for (int unsigned dd = 0; dd < DIGITS; dd++) begin
        if ((w_ay >= Y0 + rr*ROW_PITCH) && (w_ay < Y0 + rr*ROW_PITCH + CELL_H) &&
            (w_ax >= X0 + dd*CELL_PITCH) && (w_ax < X0 + dd*CELL_PITCH + CELL_W)) begin
          w_hit  = 1'b1;
          w_odd  = rr[0];
          w_mark = (r_marks[rr*5 +: 5] == 5'(dd));
          w_nib  = r_values[(rr*DIGITS + DIGITS - 1 - dd)*4 +: 4];
          w_px   = w_ax - (X0 + dd*CELL_PITCH);
          w_py   = w_ay - (Y0 + rr*ROW_PITCH);
        end
      end
    end
    w_col  = glyph_col(w_px);
    w_grow = glyph_row(w_py);
  end

  hexout_glyph u_glyph (
    .i_nibble (w_nib),
    .i_col    (w_col),
    .i_grow   (w_grow),
    .o_lit    (w_lit)
  );

  always_comb begin
    w_kind = PIX_BLANK;
    if (w_active) begin
      w_kind = PIX_BG;
      if (r_en && w_hit) begin
        if (w_mark)     w_kind = PIX_MARK;
        else if (w_lit) w_kind = PIX_SEG;
      end
    end
  end

  always_comb begin
    w_rc = '0;
    w_gc = '0;
    w_bc = '0;
    case (w_kind)
      PIX_MARK: begin
        w_rc = '1;
        w_gc = '1;
        w_bc = '1;
      end
      PIX_SEG: begin
        if (w_odd) w_gc = '1;
        else       w_rc = '1;
      end
      PIX_BG:  w_bc = CW'(1);
      default: w_bc = '0;
    endcase
  end

  // All outputs describe the counter state of the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
      r_de <= 1'b0;
      r_fs <= 1'b0;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else begin
      r_hs <= (r_hcount < H_SEND) ? HS_POL : ~HS_POL;
      r_vs <= (r_vcount < V_SEND) ? VS_POL : ~VS_POL;
      r_de <= w_active;
      r_fs <= w_frame0;
      r_r  <= w_rc;
      r_g  <= w_gc;
      r_b  <= w_bc;
    end
  end

  assign hs          = r_hs;
  assign vs          = r_vs;
  assign de          = r_de;
  assign frame_start = r_fs;
  assign r           = r_r;
  assign g           = r_g;
  assign b           = r_b;

endmodule

// File: tb/tb_vga_hexout.sv
// Scoreboard bench for vga_hexout on a reduced raster: a geometric pixel model
// predicts every output cycle, plus frame-level marker and timing checks.
module tb_vga_hexout;

  localparam int HA = 92, HFP = 4, HSY = 6, HBP = 5;
  localparam int VA = 156, VFP = 3, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int NR = 2, ND = 3, XO = 4, YO = 2, PITCH = 80;
  localparam bit HSP = 1'b0, VSP = 1'b1;
  localparam logic [9:0] RST_OBS = {~HSP, ~VSP, 8'h00};

  localparam logic [6:0] SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int         h;
    int         v;
    logic [9:0] o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] values;
  logic [9:0]  marks;
  logic        hs, vs, de, frame_start;
  logic [1:0]  r, g, b;

  exp_t        exp_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          mhc, mvc;
  logic [23:0] m_val;
  logic [9:0]  m_mk;
  logic        m_en;
  int          cyc = 0;
  int          prev_fs = 0;
  bit          have_prev = 0;
  bit          saw_fs = 0;
  int          white_cnt = 0;
  int          last_white = 0;
  int          nsteps;

  always #5 clk = ~clk;

  vga_hexout #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .HS_POL (HSP), .VS_POL (VSP),
    .ROWS (NR), .DIGITS (ND), .X0 (XO), .Y0 (YO), .ROW_PITCH (PITCH), .CW (2)
  ) dut (
    .clk (clk), .reset (rst), .enable (enable), .values (values), .marks (marks),
    .hs (hs), .vs (vs), .de (de), .r (r), .g (g), .b (b), .frame_start (frame_start)
  );

  function automatic logic [9:0] model_out(int hc, int vc, logic [23:0] vals,
                                           logic [9:0] mks, logic en);
    logic       hs_e, vs_e, de_e, fs_e, lit;
    logic [1:0] rc, gc, bc;
    logic [6:0] s;
    int         ax, ay, px, py;
    hs_e = (hc < HSY) ? HSP : ~HSP;
    vs_e = (vc < VSY) ? VSP : ~VSP;
    de_e = (hc >= HSY + HBP) && (hc < HSY + HBP + HA) && (vc >= VSY + VBP) && (vc < VSY + VBP + VA);
    fs_e = (hc == 0) && (vc == 0);
    rc = 2'd0; gc = 2'd0; bc = 2'd0;
    if (de_e) begin
      bc = 2'd1;
      ax = hc - (HSY + HBP);
      ay = vc - (VSY + VBP);
      if (en) begin
        for (int rw = 0; rw < NR; rw++) begin
          for (int d = 0; d < ND; d++) begin
            px = ax - (XO + 40*d);
            py = ay - (YO + rw*PITCH);
            if (px >= 0 && px < 32 && py >= 0 && py < 72) begin
              if (mks[rw*5 +: 5] == 5'(d)) begin
                rc = 2'd3; gc = 2'd3; bc = 2'd3;
              end else begin
                s = SEG[vals[rw*12 + (ND-1-d)*4 +: 4]];
                lit = (s[0] && py < 8) ||
                      (s[5] && px < 8 && py < 40) ||
                      (s[1] && px >= 24 && py < 40) ||
                      (s[6] && py >= 32 && py < 40) ||
                      (s[4] && px < 8 && py >= 32) ||
                      (s[2] && px >= 24 && py >= 32) ||
                      (s[3] && py >= 64);
                if (lit) begin
                  bc = 2'd0;
                  if (rw % 2 == 0) rc = 2'd3;
                  else             gc = 2'd3;
                end
              end
            end
          end
        end
      end
    end
    return {hs_e, vs_e, de_e, fs_e, rc, gc, bc};
  endfunction

  task automatic model_reset();
    mhc = 0; mvc = 0;
    m_val = '0; m_mk = '1; m_en = 1'b0;
    exp_q.delete();
  endtask

  // One clock: predict at the rising edge, compare at the falling edge.
  task automatic step();
    exp_t       e;
    logic [9:0] obs;
    @(posedge clk);
    if (!rst) begin
      e.h = mhc; e.v = mvc;
      e.o = model_out(mhc, mvc, m_val, m_mk, m_en);
      exp_q.push_back(e);
      if (mhc == 0 && mvc == 0) begin
        m_val = values; m_mk = marks; m_en = enable;
      end
      if (mhc == HT - 1) begin
        mhc = 0;
        mvc = (mvc == VT - 1) ? 0 : mvc + 1;
      end else begin
        mhc = mhc + 1;
      end
    end
    @(negedge clk);
    cyc++;
    obs = {hs, vs, de, frame_start, r, g, b};
    saw_fs = 1'b0;
    if (rst) begin
      n_assert++;
      assert (obs === RST_OBS) else begin
        n_fail++;
        $error("FAIL reset_out obs=%h exp=%h", obs, RST_OBS);
      end
      have_prev = 1'b0;
      white_cnt = 0;
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_assert++;
      assert (obs === e.o) else begin
        n_fail++;
        $error("FAIL pixel h=%0d v=%0d obs=%h exp=%h", e.h, e.v, obs, e.o);
      end
      if (frame_start) begin
        saw_fs = 1'b1;
        if (have_prev) begin
          n_assert++;
          assert (cyc - prev_fs === FRAME) else begin
            n_fail++;
            $error("FAIL fs_period obs=%0d exp=%0d", cyc - prev_fs, FRAME);
          end
        end
        prev_fs = cyc;
        have_prev = 1'b1;
        last_white = white_cnt;
        white_cnt = 0;
      end
      if (r == 2'd3 && g == 2'd3 && b == 2'd3) white_cnt++;
    end
  endtask

  task automatic run_fs(input int budget, output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!saw_fs && steps < budget);
    n_assert++;
    assert (saw_fs === 1'b1) else begin
      n_fail++;
      $error("FAIL fs_timeout obs=%0d exp=1", saw_fs);
    end
  endtask

  task automatic run_until(input int v, input int h, input int budget);
    int steps = 0;
    do begin
      step();
      steps++;
    end while (!(mvc == v && mhc == h) && steps < budget);
    n_assert++;
    assert (mvc == v && mhc == h) else begin
      n_fail++;
      $error("FAIL pos_timeout obs=%0d/%0d exp=%0d/%0d", mvc, mhc, v, h);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    values = {12'h1E7, 12'h8C4};
    marks  = {5'd3, 5'd1};
    model_reset();
    repeat (10) step();
    rst = 1'b0;

    run_fs(10, nsteps);
    n_assert++;
    assert (nsteps === 1) else begin
      n_fail++;
      $error("FAIL first_fs_latency obs=%0d exp=1", nsteps);
    end

    // Mid-frame change: only visible from the next frame.
    run_until(100, 0, FRAME);
    values = {12'hF2A, 12'h059};
    marks  = {5'd2, 5'd31};
    run_fs(FRAME + 10, nsteps);
    n_assert++;
    assert (last_white === 32*72) else begin
      n_fail++;
      $error("FAIL marker_full obs=%0d exp=%0d", last_white, 32*72);
    end

    run_until(100, 0, FRAME);
    enable = 1'b0;
    run_fs(FRAME + 10, nsteps);
    n_assert++;
    assert (last_white === 8*72) else begin
      n_fail++;
      $error("FAIL marker_clipped obs=%0d exp=%0d", last_white, 8*72);
    end

    // Asynchronous reset in the middle of a disabled frame.
    run_until(100, 50, FRAME);
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_assert++;
    assert ({hs, vs, de, frame_start, r, g, b} === RST_OBS) else begin
      n_fail++;
      $error("FAIL reset_async obs=%h exp=%h", {hs, vs, de, frame_start, r, g, b}, RST_OBS);
    end
    enable = 1'b1;
    values = {12'h0B3, 12'h7D6};
    marks  = {5'd0, 5'd2};
    repeat (3) step();
    rst = 1'b0;

    run_fs(10, nsteps);
    n_assert++;
    assert (nsteps === 1) else begin
      n_fail++;
      $error("FAIL restart_fs_latency obs=%0d exp=1", nsteps);
    end
    run_fs(FRAME + 10, nsteps);
    n_assert++;
    assert (last_white === 32*72 + 8*72) else begin
      n_fail++;
      $error("FAIL marker_restart obs=%0d exp=%0d", last_white, 32*72 + 8*72);
    end
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
